// File: rtl/bus_sync_scheduler.sv
// bus_sync_scheduler
//   Source-domain front end for a 2-FF bus synchroniser. Several requesters
//   share one unsync_bus/bus_enable crossing. A round-robin arbiter picks one
//   word at a time. The word is held with bus_enable high for HOLD_CYCLES,
//   then held with bus_enable low for GAP_CYCLES. The destination therefore
//   always sees a clean enable edge over stable data.
//
// Ports
//   CLK         in   source-domain clock, rising edge
//   RST         in   synchronous active-high reset
//   req_valid   in   [NUM_REQ]            per-requester word pending
//   req_data    in   [NUM_REQ*BUS_WIDTH]  packed words, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   req_ready   out  [NUM_REQ]            combinational one-hot accept (IDLE only)
//   unsync_bus  out  [BUS_WIDTH]          registered word toward synchroniser
//   bus_enable  out                       registered enable toward synchroniser
//   grant_id    out  [$clog2(NUM_REQ)]    requester owning current/last transfer
//   busy        out                       high whenever a transfer is in HOLD or GAP
module bus_sync_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int GW   = $clog2(NUM_REQ);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [GW-1:0]          last_grant, last_grant_nxt;
    logic [BUS_WIDTH-1:0]   bus_nxt;
    logic                   be_nxt;
    logic [GW-1:0]          grant_nxt;
    logic                   busy_nxt;

    logic [BUS_WIDTH-1:0]   words [NUM_REQ];
    logic                   win_found;
    logic [GW-1:0]          win_idx;
    logic                   accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!win_found && req_valid[GW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = GW'(cand);
            end
        end
    end

    // Ready is gated by RST so no handshake is claimed on an edge where
    // reset wins over the accept.
    assign accept = (state == S_IDLE) && win_found && !RST;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = NUM_REQ'(1) << win_idx;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        bus_nxt        = unsync_bus;
        be_nxt         = bus_enable;
        grant_nxt      = grant_id;
        busy_nxt       = busy;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    bus_nxt        = words[win_idx];
                    be_nxt         = 1'b1;
                    grant_nxt      = win_idx;
                    last_grant_nxt = win_idx;
                    busy_nxt       = 1'b1;
                    cnt_nxt        = '0;
                    state_nxt      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    be_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_GAP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                be_nxt    = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= LAST_INIT;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            unsync_bus <= bus_nxt;
            bus_enable <= be_nxt;
            grant_id   <= grant_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
